// File: rtl/uart_pkg.sv
// Shared types and defaults for the uart transmit arbiter.
// FSM encoding and parameter helpers live here.
package uart_pkg;

  localparam int DEF_NB_DATA        = 32;
  localparam int DEF_N_REQ          = 4;
  localparam int DEF_NB_TIMEOUT     = 20;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    RELEASE
  } state_t;

  function automatic int req_id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin priority picker: first set request bit
// at or above the pointer, wrapping around.
module rr_priority_picker
  import uart_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int NB_REQ_ID = req_id_width(N_REQ)
) (
  input  logic [N_REQ-1:0]     i_req,
  input  logic [NB_REQ_ID-1:0] i_ptr,
  output logic [NB_REQ_ID-1:0] o_winner,
  output logic                 o_valid
);

  logic [NB_REQ_ID-1:0] idx;

  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    idx      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = i_ptr + NB_REQ_ID'(i);
      if (i_req[idx]) begin
        o_winner = idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_32b transmit path between requesters,
// with round-robin grant, latched data and a watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NB_DATA        = DEF_NB_DATA,
  parameter int N_REQ          = DEF_N_REQ,
  parameter int NB_REQ_ID      = req_id_width(N_REQ),
  parameter int NB_TIMEOUT     = DEF_NB_TIMEOUT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_req_mode_32b,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  input  logic                     i_tx_done_8b_pulse,
  input  logic                     i_tx_done_32b_pulse,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic                     o_tx_start_8b,
  output logic                     o_tx_start_32b,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_timeout_pulse,
  output logic                     o_busy,
  output logic [NB_REQ_ID-1:0]     o_owner
);

  localparam logic [NB_TIMEOUT-1:0] WDOG_LIM =
    NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [NB_REQ_ID-1:0] rr_ptr;
  logic [NB_REQ_ID-1:0] win;
  logic                 win_valid;
  logic                 mode_32b;
  logic [NB_TIMEOUT-1:0] wdog;
  logic                 done_hit;
  logic                 wdog_hit;
  logic [NB_DATA-1:0]   req_word [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_word[k] = i_req_data[k*NB_DATA +: NB_DATA];
  end

  assign done_hit = mode_32b ? i_tx_done_32b_pulse
                             : i_tx_done_8b_pulse;
  assign wdog_hit = (wdog == WDOG_LIM);

  rr_priority_picker #(
    .N_REQ     (N_REQ),
    .NB_REQ_ID (NB_REQ_ID)
  ) u_picker (
    .i_req    (i_req),
    .i_ptr    (rr_ptr),
    .o_winner (win),
    .o_valid  (win_valid)
  );

  // Arbiter FSM with registered pulses, data latch and watchdog.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      mode_32b        <= 1'b0;
      wdog            <= '0;
      o_tx_data       <= '0;
      o_tx_start_8b   <= 1'b0;
      o_tx_start_32b  <= 1'b0;
      o_ack           <= '0;
      o_timeout_pulse <= 1'b0;
      o_busy          <= 1'b0;
      o_owner         <= '0;
    end else begin
      o_tx_start_8b   <= 1'b0;
      o_tx_start_32b  <= 1'b0;
      o_ack           <= '0;
      o_timeout_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            state          <= START;
            o_owner        <= win;
            o_tx_data      <= req_word[win];
            mode_32b       <= i_req_mode_32b[win];
            o_tx_start_32b <= i_req_mode_32b[win];
            o_tx_start_8b  <= !i_req_mode_32b[win];
            o_busy         <= 1'b1;
          end
        end
        START: begin
          wdog  <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_hit) begin
            state          <= RELEASE;
            o_ack[o_owner] <= 1'b1;
          end else if (wdog_hit) begin
            state           <= RELEASE;
            o_ack[o_owner]  <= 1'b1;
            o_timeout_pulse <= 1'b1;
          end else begin
            wdog <= wdog + NB_TIMEOUT'(1);
          end
        end
        RELEASE: begin
          rr_ptr <= o_owner + NB_REQ_ID'(1);
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter.
// Expected grants are queued at stimulus and popped at each start.
module tb_uart_tx_arbiter;

  localparam int NB_DATA = 32;
  localparam int N_REQ   = 4;
  localparam int NB_ID   = 2;
  localparam int NB_TMO  = 20;
  localparam int TMO     = 50;

  typedef struct {
    logic [NB_ID-1:0]   owner;
    logic [NB_DATA-1:0] data;
    logic               mode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] mode;
  logic [N_REQ*NB_DATA-1:0] data;
  logic d8, d32;
  logic [NB_DATA-1:0] tx_data;
  logic st8, st32;
  logic [N_REQ-1:0] ack;
  logic tmo_p, busy;
  logic [NB_ID-1:0] owner;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NB_DATA        (NB_DATA),
    .N_REQ          (N_REQ),
    .NB_REQ_ID      (NB_ID),
    .NB_TIMEOUT     (NB_TMO),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock             (clk),
    .i_reset             (rst_n),
    .i_req               (req),
    .i_req_mode_32b      (mode),
    .i_req_data          (data),
    .i_tx_done_8b_pulse  (d8),
    .i_tx_done_32b_pulse (d32),
    .o_tx_data           (tx_data),
    .o_tx_start_8b       (st8),
    .o_tx_start_32b      (st32),
    .o_ack               (ack),
    .o_timeout_pulse     (tmo_p),
    .o_busy              (busy),
    .o_owner             (owner)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit is32);
    if (is32) d32 = 1'b1;
    else d8 = 1'b1;
    step();
    d8 = 1'b0;
    d32 = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (st8 || st32) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    mode = '0;
    data = '0;
    d8 = 1'b0;
    d32 = 1'b0;
    step();
    step();
    n_cmp++;
    if ({tx_data, st8, st32, ack, tmo_p, busy, owner} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got data=%h s8=%b s32=%b ack=%b tmo=%b busy=%b own=%0d want all 0",
               tx_data, st8, st32, ack, tmo_p, busy, owner);
    end
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b0 || st8 !== 1'b0 || st32 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_noreq got busy=%b s8=%b s32=%b want 0", busy, st8, st32);
    end
  endtask

  task automatic test_single_32b();
    int lat;
    exp_t e;
    req = 4'b0100;
    mode = 4'b1111;
    data[2*NB_DATA +: NB_DATA] = 32'hDEAD_BEEF;
    sb.push_back('{owner: 2'd2, data: 32'hDEAD_BEEF, mode: 1'b1});
    wait_start(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 1 || owner !== e.owner || tx_data !== e.data ||
        st32 !== e.mode || st8 !== !e.mode) begin
      n_bad++;
      $display("FAIL single_start got lat=%0d own=%0d data=%h s8=%b s32=%b want lat=1 own=%0d data=%h mode=%b",
               lat, owner, tx_data, st8, st32, e.owner, e.data, e.mode);
    end
    req = '0;
    step();
    n_cmp++;
    if (st32 !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_pulse got s32=%b busy=%b want 0 1", st32, busy);
    end
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0);
      n_cmp++;
      if (ack !== 4'b0000) begin
        n_bad++;
        $display("FAIL single_8b_ignored got ack=%b want 0000", ack);
      end
    end
    pulse(1'b1);
    n_cmp++;
    if (ack !== 4'b0100 || busy !== 1'b1 || tmo_p !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ack got ack=%b busy=%b tmo=%b want 0100 1 0", ack, busy, tmo_p);
    end
    step();
    n_cmp++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_release got ack=%b busy=%b want 0000 0", ack, busy);
    end
  endtask

  task automatic serve_all(input logic [7:0] base, input int n);
    int lat;
    exp_t e;
    logic [N_REQ-1:0] oh;
    mode = '0;
    for (int k = 0; k < N_REQ; k++)
      data[k*NB_DATA +: NB_DATA] = {24'h0, base + 8'(k)};
    for (int i = 0; i < n; i++)
      sb.push_back('{owner: NB_ID'(i % N_REQ),
                     data: {24'h0, base + 8'(i % N_REQ)},
                     mode: 1'b0});
    req = 4'b1111;
    for (int i = 0; i < n; i++) begin
      wait_start(lat);
      e = sb.pop_front();
      n_cmp++;
      if (lat != ((i == 0) ? 1 : 2) || owner !== e.owner ||
          tx_data[7:0] !== e.data[7:0] || st8 !== 1'b1 || st32 !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_start%0d got lat=%0d own=%0d data=%h s8=%b s32=%b want own=%0d data=%h",
                 i, lat, owner, tx_data[7:0], st8, st32, e.owner, e.data[7:0]);
      end
      step();
      if (i == 0) begin
        pulse(1'b1);
        n_cmp++;
        if (ack !== 4'b0000) begin
          n_bad++;
          $display("FAIL rr_stray32 got ack=%b want 0000", ack);
        end
      end
      pulse(1'b0);
      oh = 4'b0001 << e.owner;
      n_cmp++;
      if (ack !== oh) begin
        n_bad++;
        $display("FAIL rr_ack%0d got ack=%b want %b", i, ack, oh);
      end
      if (i == n - 1) req = '0;
    end
    step();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    serve_all(8'h10, 5);
  endtask

  task automatic test_watchdog();
    int lat;
    int k;
    exp_t e;
    req = 4'b0010;
    mode = 4'b0000;
    data[1*NB_DATA +: NB_DATA] = 32'h0000_00A1;
    sb.push_back('{owner: 2'd1, data: 32'h0000_00A1, mode: 1'b0});
    wait_start(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 1 || owner !== e.owner || tx_data !== e.data || st8 !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_start got lat=%0d own=%0d data=%h s8=%b want own=%0d data=%h",
               lat, owner, tx_data, st8, e.owner, e.data);
    end
    req = '0;
    k = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (ack !== 4'b0000) begin
        k = i;
        break;
      end
    end
    n_cmp++;
    if (k != TMO + 1 || ack !== 4'b0010 || tmo_p !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_expire got cyc=%0d ack=%b tmo=%b want cyc=%0d ack=0010 tmo=1",
               k, ack, tmo_p, TMO + 1);
    end
    step();
    n_cmp++;
    if (tmo_p !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_clear got tmo=%b busy=%b want 0 0", tmo_p, busy);
    end
    req = 4'b0100;
    data[2*NB_DATA +: NB_DATA] = 32'h0000_0055;
    sb.push_back('{owner: 2'd2, data: 32'h0000_0055, mode: 1'b0});
    wait_start(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 1 || owner !== e.owner || tx_data !== e.data || st8 !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_next_start got lat=%0d own=%0d data=%h want own=%0d data=%h",
               lat, owner, tx_data, e.owner, e.data);
    end
    req = '0;
    step();
    pulse(1'b0);
    n_cmp++;
    if (ack !== 4'b0100 || tmo_p !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_next_ack got ack=%b tmo=%b want 0100 0", ack, tmo_p);
    end
    step();
  endtask

  task automatic test_done_vs_timeout();
    int lat;
    bit early;
    exp_t e;
    req = 4'b1000;
    mode = 4'b1000;
    data[3*NB_DATA +: NB_DATA] = 32'h3333_0003;
    sb.push_back('{owner: 2'd3, data: 32'h3333_0003, mode: 1'b1});
    wait_start(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 1 || owner !== e.owner || tx_data !== e.data || st32 !== 1'b1) begin
      n_bad++;
      $display("FAIL tie_start got lat=%0d own=%0d data=%h s32=%b want own=%0d data=%h",
               lat, owner, tx_data, st32, e.owner, e.data);
    end
    req = '0;
    early = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      step();
      if (ack !== 4'b0000) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_early got early_ack=%b want 0", early);
    end
    pulse(1'b1);
    n_cmp++;
    if (ack !== 4'b1000 || tmo_p !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_done_wins got ack=%b tmo=%b want 1000 0", ack, tmo_p);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    exp_t e;
    req = 4'b0001;
    mode = 4'b0001;
    data[0 +: NB_DATA] = 32'h0BAD_F00D;
    sb.push_back('{owner: 2'd0, data: 32'h0BAD_F00D, mode: 1'b1});
    wait_start(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 1 || owner !== e.owner || tx_data !== e.data || st32 !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_start got lat=%0d own=%0d data=%h s32=%b want own=%0d data=%h",
               lat, owner, tx_data, st32, e.owner, e.data);
    end
    req = '0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({tx_data, st8, st32, ack, tmo_p, busy, owner} !== '0) begin
      n_bad++;
      $display("FAIL rm_outs got data=%h s8=%b s32=%b ack=%b tmo=%b busy=%b own=%0d want all 0",
               tx_data, st8, st32, ack, tmo_p, busy, owner);
    end
    rst_n = 1'b1;
    pulse(1'b1);
    step();
    n_cmp++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_no_ack got ack=%b busy=%b want 0000 0", ack, busy);
    end
    serve_all(8'h20, 4);
  endtask

  task automatic test_data_hold();
    int lat;
    bit moved;
    exp_t e;
    req = 4'b0010;
    mode = 4'b0010;
    data[1*NB_DATA +: NB_DATA] = 32'hCAFE_0001;
    sb.push_back('{owner: 2'd1, data: 32'hCAFE_0001, mode: 1'b1});
    wait_start(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 1 || owner !== e.owner || tx_data !== e.data || st32 !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_start got lat=%0d own=%0d data=%h s32=%b want own=%0d data=%h",
               lat, owner, tx_data, st32, e.owner, e.data);
    end
    data[1*NB_DATA +: NB_DATA] = 32'h1234_5678;
    req = '0;
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tx_data !== e.data) moved = 1'b1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_data got data=%h want %h", tx_data, e.data);
    end
    pulse(1'b1);
    n_cmp++;
    if (ack !== 4'b0010 || tx_data !== e.data) begin
      n_bad++;
      $display("FAIL hold_ack got ack=%b data=%h want 0010 %h", ack, tx_data, e.data);
    end
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_single_32b();
    test_round_robin();
    test_watchdog();
    test_done_vs_timeout();
    test_reset_mid();
    test_data_hold();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_empty got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_32b transmit path between N_REQ requesters, e.g. the debug unit, register dump, memory dump and status reporter.
- Arbitrates round-robin and latches the winner's data and mode (single byte or 32-bit word).
- Fires the matching uart start pulse and waits for the matching done pulse.
- Returns a per-requester ack; a watchdog recovers if the done pulse never arrives.

Parameters:
- NB_DATA, 32, width of each requester data word and of o_tx_data
- N_REQ, 4, number of requesters (power of 2, at least 2)
- NB_REQ_ID, 2, width of the owner index, equal to log2(N_REQ)
- NB_TIMEOUT, 20, width of the watchdog counter
- TIMEOUT_CYCLES, 1000000, watchdog limit in clocks (fits NB_TIMEOUT; exceeds one 32-bit word at 9600 baud, 100 MHz)

Ports:
- i_clock  in  1  system clock; all logic on the rising edge
- i_reset  in  1  synchronous, active-low reset; 0 = reset
- i_req  in  N_REQ  request levels; bit k = requester k
- i_req_mode_32b  in  N_REQ  1 = send 4-byte word, 0 = send byte (data[7:0])
- i_req_data  in  N_REQ*NB_DATA  packed data; requester k occupies bits [k*NB_DATA +: NB_DATA]
- i_tx_done_8b_pulse  in  1  from uart_32b: one byte finished
- i_tx_done_32b_pulse  in  1  from uart_32b: full word finished
- o_tx_data  out  NB_DATA  to uart_32b i_tx_data
- o_tx_start_8b  out  1  to uart_32b i_tx_start_8b; one-cycle pulse
- o_tx_start_32b  out  1  to uart_32b i_tx_start_32b; one-cycle pulse
- o_ack  out  N_REQ  one-cycle pulse on the owner's bit when its transfer ends (normal or timeout)
- o_timeout_pulse  out  1  one cycle, together with o_ack, when the watchdog expired
- o_busy  out  1  high in every state except IDLE
- o_owner  out  NB_REQ_ID  index of the current or last granted requester

Behaviour:
- Reset (i_reset == 0 at a clock edge):
  - state = IDLE; every output 0; o_tx_data = 0
  - rr pointer = 0, so requester 0 has top priority first; watchdog = 0
  - reset mid-transfer aborts without ack; a uart transfer already under way is not stopped
- FSM states: IDLE, START, WAIT_DONE, RELEASE.
- IDLE:
  - if any i_req bit is set, pick the first set bit scanning from rr pointer upward with wrap.
  - next cycle: state = START, o_owner = winner; latch i_req_data slice into o_tx_data and latch the mode bit.
  - no request: stay in IDLE.
- START (exactly one cycle):
  - assert o_tx_start_32b if the latched mode is 1, else o_tx_start_8b; never both.
  - clear the watchdog; next state = WAIT_DONE.
- WAIT_DONE:
  - 32b mode: only i_tx_done_32b_pulse ends the transfer; intermediate i_tx_done_8b_pulse are ignored.
  - 8b mode: i_tx_done_8b_pulse ends it; a stray i_tx_done_32b_pulse is ignored.
  - watchdog increments every cycle; on reaching TIMEOUT_CYCLES-1 the transfer ends with timeout.
  - if done and timeout coincide, done wins (no timeout pulse).
- RELEASE (one cycle):
  - o_ack[o_owner] = 1; o_timeout_pulse = 1 if the transfer ended by timeout.
  - rr pointer = o_owner+1 mod N_REQ; next state = IDLE.
- Latency: request seen in IDLE at cycle t gives the start pulse at t+1 and ack one cycle after the done pulse. Back-to-back grants are separated by at least 3 idle-free cycles (RELEASE, IDLE, START).
- Handshake:
  - requester holds i_req and stable data until it is granted; data is sampled once at grant and may change afterwards.
  - requester must drop i_req in the cycle after o_ack, or it is treated as a new request (served after the others via rr).
  - dropping i_req before grant withdraws the request; dropping it after grant has no effect on the transfer.
- o_tx_data holds its latched value until the next grant; uart_32b samples it during the transfer.
- Fairness: with all requesters continuously requesting, grant order is 0,1,2,3,0,...

Decomposition:
- Shared package/header (uart_pkg):
  - FSM state encodings
  - NB_REQ_ID computation
  - default TIMEOUT_CYCLES
- One natural sub-module: rr_priority_picker. Combinational; inputs i_req and the rr pointer; outputs winner index and a valid flag.
- FSM, data latch and watchdog stay in uart_tx_arbiter.

Test Plan:
1. Single request: i_req=4'b0100, mode=1, data=0xDEADBEEF.
   - one-cycle o_tx_start_32b with o_tx_data=0xDEADBEEF.
   - inject three 8b done pulses: no ack.
   - then a 32b done pulse: o_ack=4'b0100 one cycle later; o_busy falls after RELEASE.
2. All four requesting, byte mode, data[7:0]=0x10+k.
   - starts carry 0x10, 0x11, 0x12, 0x13, 0x10 in order; each ack lands on the correct bit.
3. Watchdog: TIMEOUT_CYCLES=50, no done pulse.
   - o_ack and o_timeout_pulse high together at cycle 51 after START; next request is served normally.
4. Done pulse and watchdog expiry in the same cycle.
   - o_ack asserted, o_timeout_pulse stays 0.
5. Reset pulled low during WAIT_DONE.
   - all outputs 0 next cycle, no ack.
   - next request from requester 3 is granted only after requesters 0..2 when all four request (rr=0).
6. Requester 1 changes i_req_data the cycle after START.
   - o_tx_data keeps the originally latched value until ack.
